// File: rtl/dbus_pkg.sv
// dbus_pkg: shared definitions for the data-bus responder.
// Holds the MMIO register offsets, the STATUS bit positions and the
// address-region enum used by the decoder.
package dbus_pkg;

  // Byte offsets from MMIO_BASE
  localparam logic [31:0] OFF_CYCLE   = 32'h00;
  localparam logic [31:0] OFF_CMP     = 32'h04;
  localparam logic [31:0] OFF_STATUS  = 32'h08;
  localparam logic [31:0] OFF_CONSOLE = 32'h0C;
  localparam logic [31:0] OFF_GPIO    = 32'h10;
  // One past the last register; used for the MMIO range check
  localparam logic [31:0] OFF_END     = 32'h14;

  // STATUS bit positions
  localparam int ST_TMATCH = 0;
  localparam int ST_FULL   = 1;
  localparam int ST_EMPTY  = 2;
  localparam int ST_OVF    = 3;
  localparam int ST_DECERR = 4;

  typedef enum logic [1:0] {
    REGION_RAM,
    REGION_MMIO,
    REGION_UNMAPPED
  } dbus_region_e;

endpackage

// File: rtl/dbus_fifo.sv
// dbus_fifo: generic synchronous FIFO used for the console byte queue.
// Ports: clk, reset (async, active-high); push/push_dat in; pop in;
//        pop_dat (head entry, 0 when empty), full, empty, count, ovf (pulse).
module dbus_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [W-1:0]               push_dat,
  input  logic                       pop,
  output logic [W-1:0]               pop_dat,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       ovf
);
  // Purpose: DEPTH-entry queue with registered occupancy, no push-to-pop bypass.
  // Latency: a pushed entry is visible at the head one edge after the push.
  // Backpressure: a push while full is accepted only if a pop happens the same cycle; otherwise dropped with ovf.

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt_q;
  logic          push_ok, pop_ok;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign pop_ok  = pop & ~empty;
  // A full FIFO can still take a push when the head leaves in the same cycle
  assign push_ok = push & (~full | pop_ok);
  assign ovf     = push & full & ~pop_ok;
  // Gate the head so an unwritten slot never leaks onto the port while empty
  assign pop_dat = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      cnt_q <= cnt_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  // Storage is not reset; occupancy alone decides what is valid
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/dbus_responder.sv
// dbus_responder: data-side slave for the single-cycle core. Decodes the
// byte address into word RAM, an MMIO block (cycle counter / compare timer,
// STATUS, console FIFO, GPIO) or an unmapped hole.
// Ports: clk, reset (async, active-high); we/addr/wdata/rdata core bus;
//        tx_data/tx_valid/tx_ready console drain; gpio_out; timer_irq.
// Build option: define DBUS_TIMER_EN to implement CYCLE/CMP/TMATCH;
// without it those registers read 0 and timer_irq stays 0.
module dbus_responder
  import dbus_pkg::*;
#(
  parameter int          RAM_WORDS  = 64,
  parameter logic [31:0] MMIO_BASE  = 32'h400,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  gpio_out,
  output logic        timer_irq
);
  // Purpose: single-cycle data memory plus MMIO peripherals behind one decoder.
  // Latency: reads combinational (0 cycles); writes take effect at the rising edge.
  // Backpressure: none on the core side; console drains by valid/ready, overflowing pushes are dropped and flagged.

  localparam int AW = $clog2(RAM_WORDS);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  dbus_region_e  region;
  logic [31:0]   mmio_off;
  logic [AW-1:0] ram_idx;
  logic [31:0]   ram [RAM_WORDS];

  logic          wr_mmio, wr_status, wr_console, wr_gpio, decerr_set;
  logic [31:0]   cycle_q, cmp_q;
  logic          tmatch_set;
  logic          tmatch_q, ovf_q, decerr_q;
  logic [7:0]    gpio_q;

  logic          fifo_full, fifo_empty, fifo_ovf, fifo_pop;
  logic [CW-1:0] fifo_count;

  logic          unused_ok;
  assign unused_ok = &{1'b0, addr[1:0]};

  // Wraps to a huge value for addresses below MMIO_BASE, so one
  // unsigned compare covers both ends of the register window.
  assign mmio_off = {addr[31:2], 2'b00} - MMIO_BASE;
  assign ram_idx  = addr[AW+1:2];

  always_comb begin
    region = REGION_UNMAPPED;
    if (addr[31:2] < 30'(RAM_WORDS)) region = REGION_RAM;
    else if (mmio_off < OFF_END)     region = REGION_MMIO;
  end

  assign wr_mmio    = we && (region == REGION_MMIO);
  assign wr_status  = wr_mmio && (mmio_off == OFF_STATUS);
  assign wr_console = wr_mmio && (mmio_off == OFF_CONSOLE);
  assign wr_gpio    = wr_mmio && (mmio_off == OFF_GPIO);
  assign decerr_set = we && (region == REGION_UNMAPPED);

  // Word RAM, no reset so contents survive a reset pulse
  always_ff @(posedge clk) begin
    if (we && (region == REGION_RAM)) ram[ram_idx] <= wdata;
  end

`ifdef DBUS_TIMER_EN
  logic wr_cmp;
  assign wr_cmp = wr_mmio && (mmio_off == OFF_CMP);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_q <= '0;
      cmp_q   <= '1;
    end else begin
      cycle_q <= cycle_q + 32'd1;
      if (wr_cmp) cmp_q <= wdata;
    end
  end

  // Compare uses pre-edge values, so the flag lands on the matching edge
  assign tmatch_set = (cycle_q == cmp_q);
`else
  assign cycle_q    = '0;
  assign cmp_q      = '0;
  assign tmatch_set = 1'b0;
`endif

  // Sticky flags: hardware set wins over a simultaneous W1C
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmatch_q <= 1'b0;
      ovf_q    <= 1'b0;
      decerr_q <= 1'b0;
      gpio_q   <= '0;
    end else begin
      tmatch_q <= tmatch_set | (tmatch_q & ~(wr_status & wdata[ST_TMATCH]));
      ovf_q    <= fifo_ovf   | (ovf_q    & ~(wr_status & wdata[ST_OVF]));
      decerr_q <= decerr_set | (decerr_q & ~(wr_status & wdata[ST_DECERR]));
      if (wr_gpio) gpio_q <= wdata[7:0];
    end
  end

  assign fifo_pop = tx_valid & tx_ready;

  dbus_fifo #(
    .W     (8),
    .DEPTH (FIFO_DEPTH)
  ) u_console_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (wr_console),
    .push_dat (wdata[7:0]),
    .pop      (fifo_pop),
    .pop_dat  (tx_data),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count),
    .ovf      (fifo_ovf)
  );

  assign tx_valid  = ~fifo_empty;
  assign gpio_out  = gpio_q;
  assign timer_irq = tmatch_q;

  always_comb begin
    rdata = '0;
    case (region)
      REGION_RAM:  rdata = ram[ram_idx];
      REGION_MMIO: begin
        case (mmio_off)
          OFF_CYCLE:   rdata = cycle_q;
          OFF_CMP:     rdata = cmp_q;
          OFF_STATUS: begin
            rdata[ST_TMATCH] = tmatch_q;
            rdata[ST_FULL]   = fifo_full;
            rdata[ST_EMPTY]  = fifo_empty;
            rdata[ST_OVF]    = ovf_q;
            rdata[ST_DECERR] = decerr_q;
          end
          OFF_CONSOLE: rdata = 32'(fifo_count);
          OFF_GPIO:    rdata = {24'd0, gpio_q};
          default:     rdata = '0;
        endcase
      end
      default:     rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_dbus_responder.sv
// tb_dbus_responder: directed-vector bench for dbus_responder.
// Inputs change 1 time unit after each rising edge; outputs are sampled
// after they settle and before the next rising edge.
module tb_dbus_responder;

  localparam logic [31:0] BASE    = 32'h400;
  localparam logic [31:0] A_CYCLE = BASE + 32'h00;
  localparam logic [31:0] A_CMP   = BASE + 32'h04;
  localparam logic [31:0] A_STAT  = BASE + 32'h08;
  localparam logic [31:0] A_CON   = BASE + 32'h0C;
  localparam logic [31:0] A_GPIO  = BASE + 32'h10;
`ifdef DBUS_TIMER_EN
  localparam logic [31:0] CMP_RST = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] CMP_RST = 32'h0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        we = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [7:0]  gpio_out;
  logic        timer_irq;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dbus_responder #(
    .RAM_WORDS  (64),
    .MMIO_BASE  (BASE),
    .FIFO_DEPTH (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .gpio_out  (gpio_out),
    .timer_irq (timer_irq)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    tick();
    we    = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr = a;
    we   = 1'b0;
    #1;
    chk(tag, rdata, exp);
  endtask

  logic [31:0] c0, c1;
  logic        any_irq;

  initial begin
    // Reset
    repeat (3) tick();
    reset = 1'b0;
    tick();
    rd("status_rst", A_STAT, 32'h4);
    chk("gpio_rst", 32'(gpio_out), 32'h0);
    chk("txv_rst", 32'(tx_valid), 32'h0);
    chk("irq_rst", 32'(timer_irq), 32'h0);
    rd("cmp_rst", A_CMP, CMP_RST);
    rd("con_rst", A_CON, 32'h0);

    // RAM and GPIO
    wr(32'h0, 32'hA5A5_5A5A);
    wr(32'h64, 32'd7);
    rd("ram_64", 32'h64, 32'd7);
    rd("ram_0", 32'h0, 32'hA5A5_5A5A);
    rd("ram_alias_lo", 32'h66, 32'd7);
    addr = 32'h64; wdata = 32'd9; we = 1'b1;
    #1 chk("ram_rw_same", rdata, 32'd7);
    tick(); we = 1'b0;
    rd("ram_64_new", 32'h64, 32'd9);
    wr(A_GPIO, 32'h1FF);
    chk("gpio_out", 32'(gpio_out), 32'hFF);
    rd("gpio_rd", A_GPIO, 32'hFF);

    // Console push then drain
    tx_ready = 1'b0;
    addr = A_CON; wdata = 32'h41; we = 1'b1;
    #1 chk("txv_nobypass", 32'(tx_valid), 32'h0);
    tick(); we = 1'b0;
    chk("txv_after1", 32'(tx_valid), 32'h1);
    wr(A_CON, 32'h42);
    chk("txd_head", 32'(tx_data), 32'h41);
    rd("con_cnt2", A_CON, 32'h2);
    tx_ready = 1'b1;
    #1 chk("drain_41", 32'(tx_data), 32'h41);
    tick();
    chk("drain_v2", 32'(tx_valid), 32'h1);
    chk("drain_42", 32'(tx_data), 32'h42);
    tick();
    chk("drain_empty", 32'(tx_valid), 32'h0);
    tx_ready = 1'b0;

    // Overflow
    for (int i = 0; i < 4; i++) wr(A_CON, 32'h10 + 32'(i));
    rd("stat_full", A_STAT, 32'h02);
    wr(A_CON, 32'h14);
    rd("stat_ovf", A_STAT, 32'h0A);
    rd("con_cnt4", A_CON, 32'h4);
    chk("ovf_head", 32'(tx_data), 32'h10);
    wr(A_STAT, 32'h8);
    rd("ovf_clr", A_STAT, 32'h02);
    tx_ready = 1'b1;
    wr(A_CON, 32'h15);
    tx_ready = 1'b0;
    rd("push_pop_full", A_STAT, 32'h02);
    rd("con_cnt4b", A_CON, 32'h4);
    chk("head_after_pp", 32'(tx_data), 32'h11);

    // Unmapped
    wr(32'h800, 32'h55);
    rd("stat_decerr", A_STAT, 32'h12);
    rd("ram_0_kept", 32'h0, 32'hA5A5_5A5A);
    rd("ram_64_kept", 32'h64, 32'd9);
    rd("unmap_rd", 32'h800, 32'h0);
    rd("hole_rd", 32'h200, 32'h0);
    wr(A_STAT, 32'h10);
    rd("decerr_clr", A_STAT, 32'h02);
    addr = 32'h800; tick(); tick();
    rd("rd_no_decerr", A_STAT, 32'h02);

    // Timer
`ifdef DBUS_TIMER_EN
    addr = A_CYCLE; #1 c0 = rdata;
    tick();
    c1 = rdata;
    chk("cycle_inc", c1, c0 + 32'd1);
    wr(A_CMP, c0 + 32'd4);
    chk("irq_e0", 32'(timer_irq), 32'h0);
    tick();
    chk("irq_e1", 32'(timer_irq), 32'h0);
    tick();
    chk("irq_e2", 32'(timer_irq), 32'h0);
    tick();
    chk("irq_e3", 32'(timer_irq), 32'h1);
    rd("stat_tmatch", A_STAT, 32'h03);
    rd("cmp_rd", A_CMP, c0 + 32'd4);
    wr(A_STAT, 32'h1);
    chk("irq_clr", 32'(timer_irq), 32'h0);
`else
    rd("cycle_off", A_CYCLE, 32'h0);
    wr(A_CMP, 32'h5);
    rd("cmp_off", A_CMP, 32'h0);
    rd("no_decerr_tmr", A_STAT, 32'h02);
    any_irq = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      any_irq = any_irq | timer_irq;
    end
    chk("irq_never", 32'(any_irq), 32'h0);
`endif

    // Reset during drain
    tx_ready = 1'b1;
    tick();
    chk("pre_rst_txv", 32'(tx_valid), 32'h1);
    #2 reset = 1'b1;
    #1 chk("rst_txv", 32'(tx_valid), 32'h0);
    chk("rst_gpio", 32'(gpio_out), 32'h0);
    rd("rst_stat", A_STAT, 32'h4);
    tick();
    reset = 1'b0;
    tx_ready = 1'b0;
    tick();
    rd("rst_ram_kept", 32'h64, 32'd9);
    rd("rst_cmp", A_CMP, CMP_RST);
    rd("rst_con", A_CON, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
